// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler
// Turns button edges and a gravity timer into single movement commands for
// the game FSM, one at a time over a valid/ready handshake. Also owns the
// level register and the level-dependent drop period.
module tetris_move_scheduler #(
   parameter logic [23:0] GRAVITY_INIT = 24'd12_500_000,
   parameter logic [23:0] GRAVITY_STEP = 24'd750_000,
   parameter logic [23:0] GRAVITY_MIN  = 24'd1_250_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        right,
   input  logic        left,
   input  logic        rr,
   input  logic        rl,
   input  logic        level_up,
   input  logic        move_ready,
   output logic        move_valid,
   output logic [2:0]  move,
   output logic [3:0]  level,
   output logic [23:0] drop_period
);

   // move_t encoding
   localparam logic [2:0] MV_NONE  = 3'd0;
   localparam logic [2:0] MV_RIGHT = 3'd1;
   localparam logic [2:0] MV_LEFT  = 3'd2;
   localparam logic [2:0] MV_ROR   = 3'd3;
   localparam logic [2:0] MV_ROL   = 3'd4;
   localparam logic [2:0] MV_DOWN  = 3'd5;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_ISSUE = 1'b1;

   // Pending vector bit positions, lowest index = highest priority.
   localparam int P_DOWN  = 0;
   localparam int P_RIGHT = 1;
   localparam int P_LEFT  = 2;
   localparam int P_ROR   = 3;
   localparam int P_ROL   = 4;

   logic        state;
   logic [2:0]  move_q;
   logic [4:0]  pend;
   logic [23:0] cnt;
   logic [3:0]  btn_prev;
   logic [3:0]  btn;
   logic [3:0]  req;
   logic        tick;
   logic [4:0]  grant;
   logic [2:0]  grant_move;
   logic [4:0]  pend_set;
   logic [4:0]  pend_clr;
   logic [4:0]  pend_next;
   logic [27:0] lvl_scaled;
   logic [23:0] next_period;

   assign btn  = {rl, rr, left, right};
   assign req  = btn & ~btn_prev;
   // drop_period is never below 2, so the subtraction cannot wrap.
   assign tick = en && (cnt >= (drop_period - 24'd1));

   assign move_valid = (state == ST_ISSUE);
   assign move       = (state == ST_ISSUE) ? move_q : MV_NONE;

   // Fixed-priority grant over the pending requests.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      grant      = '0;
      grant_move = MV_NONE;
      if (pend[P_DOWN]) begin
         grant[P_DOWN] = 1'b1;
         grant_move    = MV_DOWN;
      end else if (pend[P_RIGHT]) begin
         grant[P_RIGHT] = 1'b1;
         grant_move     = MV_RIGHT;
      end else if (pend[P_LEFT]) begin
         grant[P_LEFT] = 1'b1;
         grant_move    = MV_LEFT;
      end else if (pend[P_ROR]) begin
         grant[P_ROR] = 1'b1;
         grant_move   = MV_ROR;
      end else if (pend[P_ROL]) begin
         grant[P_ROL] = 1'b1;
         grant_move   = MV_ROL;
      end
   end

   // Pending update: a new event arriving with a grant of the same bit wins.
   always_comb begin
      pend_set  = {req[3], req[2], req[1], req[0], tick};
      pend_clr  = (state == ST_IDLE) ? grant : 5'd0;
      pend_next = (pend & ~pend_clr) | pend_set;
   end

   // Level-dependent drop period, floored at GRAVITY_MIN (28-bit product).
   always_comb begin
      lvl_scaled  = {24'd0, level} * {4'd0, GRAVITY_STEP};
      next_period = GRAVITY_MIN;
      if (lvl_scaled <= {4'd0, GRAVITY_INIT}) begin
         if ((GRAVITY_INIT - lvl_scaled[23:0]) >= GRAVITY_MIN)
            next_period = GRAVITY_INIT - lvl_scaled[23:0];
      end
   end

   // Scheduler state: edge detect, gravity counter, pending bits, handshake FSM.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state    <= ST_IDLE;
         move_q   <= MV_NONE;
         pend     <= '0;
         cnt      <= '0;
         btn_prev <= '0;
      end else begin
         btn_prev <= btn;
         if (!en) begin
            state  <= ST_IDLE;
            move_q <= MV_NONE;
            pend   <= '0;
            cnt    <= '0;
         end else begin
            cnt  <= tick ? 24'd0 : cnt + 24'd1;
            pend <= pend_next;
            if (state == ST_IDLE) begin
               if (grant != 5'd0) begin
                  move_q <= grant_move;
                  state  <= ST_ISSUE;
               end
            end else if (move_ready) begin
               move_q <= MV_NONE;
               state  <= ST_IDLE;
            end
         end
      end
   end

   // Level register and registered drop period (lags level by one cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         level       <= 4'd0;
         drop_period <= GRAVITY_INIT;
      end else begin
         drop_period <= next_period;
         if (level_up && (level != 4'd15))
            level <= level + 4'd1;
      end
   end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// tb_tetris_move_scheduler
// Directed scenarios followed by a randomized phase, all compared cycle by
// cycle against a behavioural model of the scheduler rules.
module tb_tetris_move_scheduler;

   localparam int INIT = 8;
   localparam int STEP = 2;
   localparam int MIN  = 2;

   localparam logic [2:0] MV_NONE  = 3'd0;
   localparam logic [2:0] MV_RIGHT = 3'd1;
   localparam logic [2:0] MV_LEFT  = 3'd2;
   localparam logic [2:0] MV_ROR   = 3'd3;
   localparam logic [2:0] MV_ROL   = 3'd4;
   localparam logic [2:0] MV_DOWN  = 3'd5;

   logic        clk = 1'b0;
   logic        rst, en, right, left, rr, rl, level_up, move_ready;
   logic        move_valid;
   logic [2:0]  move;
   logic [3:0]  level;
   logic [23:0] drop_period;

   always #5 clk = ~clk;

   tetris_move_scheduler #(
      .GRAVITY_INIT(24'd8),
      .GRAVITY_STEP(24'd2),
      .GRAVITY_MIN (24'd2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .right      (right),
      .left       (left),
      .rr         (rr),
      .rl         (rl),
      .level_up   (level_up),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move       (move),
      .level      (level),
      .drop_period(drop_period)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: pending requests listed in priority order.
   logic [2:0] prio_code [5] = '{MV_DOWN, MV_RIGHT, MV_LEFT, MV_ROR, MV_ROL};
   bit         pend [5];
   bit         m_prev [4];
   bit         m_issue;
   logic [2:0] m_move;
   int         m_cnt, m_level, m_period;

   // Commands actually accepted by the handshake, by move code.
   int acc [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int period_of(input int l);
      int p;
      p = INIT - l * STEP;
      return (p < MIN) ? MIN : p;
   endfunction

   task automatic model_edge();
      bit btn [4];
      bit req [4];
      bit tick;
      int new_period;
      btn = '{right, left, rr, rl};
      if (rst) begin
         m_issue  = 0;
         m_move   = MV_NONE;
         for (int i = 0; i < 5; i++) pend[i] = 0;
         for (int i = 0; i < 4; i++) m_prev[i] = 0;
         m_cnt    = 0;
         m_level  = 0;
         m_period = INIT;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         req[i]    = btn[i] && !m_prev[i];
         m_prev[i] = btn[i];
      end
      if (!en) begin
         m_issue = 0;
         m_move  = MV_NONE;
         for (int i = 0; i < 5; i++) pend[i] = 0;
         m_cnt = 0;
      end else begin
         tick  = (m_cnt + 1 >= m_period);
         m_cnt = tick ? 0 : m_cnt + 1;
         if (!m_issue) begin
            for (int i = 0; i < 5; i++) begin
               if (pend[i]) begin
                  m_issue = 1;
                  m_move  = prio_code[i];
                  pend[i] = 0;
                  break;
               end
            end
         end else if (move_ready) begin
            m_issue = 0;
         end
         if (tick) pend[0] = 1;
         for (int i = 0; i < 4; i++) if (req[i]) pend[i+1] = 1;
      end
      new_period = period_of(m_level);
      if (level_up && m_level < 15) m_level++;
      m_period = new_period;
   endtask

   // One clock: update the model from the driven inputs, take the edge, compare.
   task automatic cycle();
      if (move_valid === 1'b1 && move_ready === 1'b1) acc[move]++;
      model_edge();
      @(posedge clk);
      #1;
      check("move_valid",  32'(move_valid),  32'(m_issue));
      check("move",        32'(move),        32'(m_issue ? m_move : MV_NONE));
      check("level",       32'(level),       32'(m_level));
      check("drop_period", 32'(drop_period), 32'(m_period));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   int a_right, a_ror, a_left, a_rol;

   initial begin
      for (int i = 0; i < 8; i++) acc[i] = 0;
      rst = 1; en = 0; right = 0; left = 0; rr = 0; rl = 0;
      level_up = 0; move_ready = 0;

      // Reset for two cycles, reset values checked by cycle().
      cycles(2);
      check("reset_valid", 32'(move_valid), 32'd0);
      check("reset_drop",  32'(drop_period), 32'd8);

      // Gravity: first DOWN visible after edge 9.
      rst = 0; en = 1; move_ready = 1;
      cycles(8);
      check("pre_first_down", 32'(move_valid), 32'd0);
      cycle();
      check("first_down_valid", 32'(move_valid), 32'd1);
      check("first_down_move",  32'(move), 32'(MV_DOWN));

      // Priority: right and rr rise on the edge the counter wraps (edge 16).
      cycles(6);
      right = 1; rr = 1;
      a_right = acc[MV_RIGHT]; a_ror = acc[MV_ROR];
      cycles(20);
      check("one_right", 32'(acc[MV_RIGHT] - a_right), 32'd1);
      check("one_ror",   32'(acc[MV_ROR] - a_ror),     32'd1);
      right = 0; rr = 0;
      cycles(3);

      // Handshake stall with left.
      move_ready = 0; left = 1;
      a_left = acc[MV_LEFT];
      cycles(6);
      left = 0;
      cycles(4);
      move_ready = 1;
      cycles(8);
      check("one_left", 32'(acc[MV_LEFT] - a_left), 32'd1);

      // Merge of gravity ticks while stalled.
      move_ready = 0;
      cycles(20);
      move_ready = 1;
      cycles(20);

      // Level saturation.
      for (int i = 0; i < 20; i++) begin
         level_up = 1; cycle();
         level_up = 0; cycle();
      end
      check("level_sat", 32'(level), 32'd15);
      check("drop_sat",  32'(drop_period), 32'd2);
      cycles(8);

      // en abort with RIGHT and ROL pending behind a stalled DOWN.
      move_ready = 0;
      cycles(2);
      right = 1; rl = 1;
      cycles(3);
      en = 0;
      cycle();
      check("abort_valid", 32'(move_valid), 32'd0);
      check("abort_move",  32'(move), 32'(MV_NONE));
      en = 1; move_ready = 1;
      a_right = acc[MV_RIGHT]; a_rol = acc[MV_ROL];
      cycles(12);
      check("abort_no_right", 32'(acc[MV_RIGHT] - a_right), 32'd0);
      check("abort_no_rol",   32'(acc[MV_ROL] - a_rol),     32'd0);
      right = 0; rl = 0;
      cycles(2);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 499) == 0);
         en         = ($urandom_range(0, 63) != 0);
         move_ready = ($urandom_range(0, 2) != 0);
         level_up   = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 5) == 0) right = ~right;
         if ($urandom_range(0, 5) == 0) left  = ~left;
         if ($urandom_range(0, 5) == 0) rr    = ~rr;
         if ($urandom_range(0, 5) == 0) rl    = ~rl;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tetris_move_scheduler.md
# tetris_move_scheduler

Schedules and arbitrates piece movement commands for the Tetris game FSM. It turns raw button levels (right, left, rr, rl) and an internal gravity timer into a stream of single `move_t` commands. Commands are issued one at a time over a valid/ready handshake, and the FSM acknowledges each one when its tracker completes. It also owns the level register and the level-dependent drop period.

## Interface
Parameters:
- `GRAVITY_INIT`, default 24'd12_500_000: drop period in clk cycles at level 0.
- `GRAVITY_STEP`, default 24'd750_000: period reduction per level.
- `GRAVITY_MIN`, default 24'd1_250_000: floor on the drop period; must be ≥ 2.

Ports:
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: game active, high while the FSM is in a piece state (A1..G4). Low clears the scheduler.
- `right`, `left`, `rr`, `rl` input 1 each: button levels, already synchronized and debounced.
- `level_up` input 1: one-cycle pulse that increments the level.
- `move_ready` input 1: FSM accepts the current command (tracker complete).
- `move_valid` output 1: a command is presented.
- `move` output `move_t` (3): RIGHT, LEFT, ROR, ROL, DOWN or NONE. NONE whenever `move_valid` = 0.
- `level` output 4: current level, 0..15.
- `drop_period` output 24: current gravity period in cycles.

## Operation
- Edge detect: a previous-value register per button. A request is a cycle where the button is 1 and its previous value is 0.
- Pending bits:
  - `p_right`, `p_left`, `p_ror`, `p_rol`: each is set by its request edge.
  - `p_down`: set by a gravity tick.
  - Repeated events while a bit is already set merge into a single pending request; there is no counting.
- Gravity counter (24 bit):
  - Increments every cycle while `en` = 1.
  - When `cnt >= drop_period - 1`: `cnt` goes to 0 and `p_down` is set.
  - The `>=` compare makes a mid-count period decrease take effect immediately.
- Level:
  - `level_up` increments `level`, saturating at 15.
  - `drop_period = max(GRAVITY_INIT - level*GRAVITY_STEP, GRAVITY_MIN)`.
  - Compute in 28 bits. If the subtraction underflows, the result is GRAVITY_MIN.
  - `drop_period` is registered and updates the cycle after `level` changes.
- State machine (2 states):
  - **IDLE**: `move_valid` = 0. If any pending bit is set, grant the highest priority: DOWN > RIGHT > LEFT > ROR > ROL. Load `move`, clear the granted bit, go to ISSUE.
  - **ISSUE**: `move_valid` = 1 and `move` is held stable. On `move_ready` = 1, go to IDLE.
  - Back-to-back issues are therefore separated by at least one IDLE cycle.
- `move_ready` sampled while in IDLE is ignored.
- Simultaneous set and clear of the same pending bit: set wins, so the new event stays pending.
- `en` = 0, at any time including mid-handshake, on the next edge:
  - state goes to IDLE, `move_valid` = 0, `move` = NONE;
  - all pending bits and `cnt` clear;
  - edge-detect registers keep tracking, so a button held across `en` rising does not fire.
  - `level` and `drop_period` are retained.
- `rst` = 1 on an edge: state IDLE, pending bits 0, `cnt` 0, button previous values 0, `level` 0, `drop_period` = GRAVITY_INIT.

## Timing
- Reset values:
  - `move_valid` = 0, `move` = NONE, `level` = 0, `drop_period` = GRAVITY_INIT.
  - `rst` overrides `en`.
- Button latency, when idle and nothing else is pending:
  - button first sampled 1 at edge k sets the pending bit at edge k;
  - `move_valid` = 1 after edge k+1.
- Gravity: the first DOWN tick fires at edge `drop_period` after `en` rises. The counter value after edge n is n mod period.
- Handshake: `move_ready` high at edge j with ISSUE drops `move_valid` after edge j. The earliest next `move_valid` is after edge j+1.
- Throughput: at most one command per 2 cycles.
- `level_up` at edge k: `level` updates at k, `drop_period` updates at k+1.

## Test plan
Parameters for all scenarios: GRAVITY_INIT=8, GRAVITY_STEP=2, GRAVITY_MIN=2.
- **Reset and gravity**: `rst` for 2 cycles, then `en`=1 and `move_ready` tied 1.
  - `move_valid` first high after edge 9 with `move`=DOWN.
  - Then one DOWN every 8 cycles; `level`=0 and `drop_period`=8 throughout.
- **Priority**: `right` and `rr` rise on the same edge the counter wraps, with `move_ready`=1.
  - Issue order is DOWN, RIGHT, ROR, each spaced 2 cycles.
  - Holding `right` high issues no second RIGHT.
- **Handshake stall**: `left` press, `move_ready`=0 for 5 cycles, then 1.
  - `move_valid` stays 1 and `move`=LEFT stable throughout.
  - Falls the cycle after the ready edge; exactly one LEFT is issued.
- **Merge/overflow**: `move_ready`=0 for 20 cycles.
  - `p_down` is set once; after release exactly one DOWN is issued, and the next DOWN follows the counter phase.
- **Level saturation**: 20 `level_up` pulses.
  - `level` goes 1..15 and holds at 15.
  - `drop_period` goes 6, 4, 2 and then holds at 2; DOWN issues every 2 cycles when ready.
- **en abort**: `en`=0 mid-ISSUE with RIGHT and ROL pending.
  - Next cycle `move_valid`=0, `move`=NONE, and pending is cleared.
  - After `en`=1 with `rl` still held, no command issues until the gravity tick at cycle 2.
